// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
// Shares one WIDTH-bit bitwise logic unit (AND / OR / XOR / ANDN) between two
// requesters. A round-robin arbiter picks one request per cycle, and a
// single-entry result register returns the result one cycle later, tagged
// with the requester id.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   req0_valid/ready/op/a/b      requester 0 valid/ready handshake and payload
//   req1_valid/ready/op/a/b      requester 1 valid/ready handshake and payload
//   rsp_valid/ready/id/data      registered response channel
//
// op encoding: 00 AND, 01 OR, 10 XOR, 11 ANDN (a & ~b).
module logic_unit_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_t;

    buf_state_t       state_r;
    buf_state_t       state_next_s;
    logic             last_grant_r;
    logic             rsp_id_r;
    logic [WIDTH-1:0] rsp_data_r;

    logic             slot_free_s;
    logic             grant_valid_s;
    logic             grant_id_s;
    logic             accept_s;
    logic [1:0]       sel_op_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;

    // Shared bitwise logic unit.
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] res;
        case (op)
            2'b00:   res = a & b;
            2'b01:   res = a | b;
            2'b10:   res = a ^ b;
            2'b11:   res = a & ~b;
            default: res = {WIDTH{1'b0}};
        endcase
        return res;
    endfunction

    // Slot is free when the buffer is empty or its result drains this cycle.
    always_comb begin
        slot_free_s = 1'b0;
        case (state_r)
            ST_EMPTY: slot_free_s = 1'b1;
            ST_FULL:  slot_free_s = rsp_ready;
            default:  slot_free_s = 1'b0;
        endcase
    end

    // Round-robin grant; on contention the requester not served last wins.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if (slot_free_s) begin
            if (req0_valid && req1_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = ~last_grant_r;
            end else if (req0_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = 1'b0;
            end else if (req1_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = 1'b1;
            end else begin
                grant_valid_s = 1'b0;
                grant_id_s    = 1'b0;
            end
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end
    end

    // A grant is an accept (grant implies valid); nothing is accepted in reset.
    always_comb begin
        accept_s = grant_valid_s & ~reset;
        if (grant_id_s) begin
            sel_op_s = req1_op;
            sel_a_s  = req1_a;
            sel_b_s  = req1_b;
        end else begin
            sel_op_s = req0_op;
            sel_a_s  = req0_a;
            sel_b_s  = req0_b;
        end
    end

    // Buffer next-state: refill wins over drain so back-to-back ops stay FULL.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_next_s = ST_FULL;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_s) begin
                    state_next_s = ST_FULL;
                end else if (rsp_ready) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: state_next_s = ST_EMPTY;
        endcase
    end

    // Buffer state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Result, id and round-robin pointer; they change only on an accept.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_data_r   <= {WIDTH{1'b0}};
            rsp_id_r     <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            rsp_data_r   <= apply_op(sel_op_s, sel_a_s, sel_b_s);
            rsp_id_r     <= grant_id_s;
            last_grant_r <= grant_id_s;
        end else begin
            rsp_data_r   <= rsp_data_r;
            rsp_id_r     <= rsp_id_r;
            last_grant_r <= last_grant_r;
        end
    end

    // Output decode: response fields come straight from registers.
    always_comb begin
        rsp_valid  = (state_r == ST_FULL);
        rsp_id     = rsp_id_r;
        rsp_data   = rsp_data_r;
        req0_ready = grant_valid_s & (grant_id_s == 1'b0) & ~reset;
        req1_ready = grant_valid_s & (grant_id_s == 1'b1) & ~reset;
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: a cycle-level model of the response
// slot and round-robin pointer, compared against the DUT every cycle, plus
// hand-computed literal expectations for each scenario.
module tb_logic_unit_arbiter;

    localparam int W = 32;

    logic         clock;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_data;

    int checks = 0;
    int errors = 0;

    logic_unit_arbiter #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model state: contents of the single result slot and who was served last.
    bit           m_known = 1'b0;
    bit           m_valid;
    bit           m_id;
    bit           m_last;
    logic [W-1:0] m_data;

    function automatic logic [W-1:0] op_result(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        if (op == 2'd0) return a & b;
        if (op == 2'd1) return a | b;
        if (op == 2'd2) return a ^ b;
        return a & ~b;
    endfunction

    // Which requester the specification says must see ready this cycle (-1: none).
    function automatic int winner();
        bit room;
        room = !m_valid || rsp_ready;
        if (reset || !room) return -1;
        if (req0_valid && req1_valid) return m_last ? 0 : 1;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    // Model update on the clock edge.
    always @(posedge clock) begin : model_upd
        int w;
        w = winner();
        if (reset) begin
            m_known <= 1'b1;
            m_valid <= 1'b0;
            m_id    <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b1;
        end else if (m_known) begin
            if (w == 0) begin
                m_valid <= 1'b1; m_id <= 1'b0; m_last <= 1'b0;
                m_data  <= op_result(req0_op, req0_a, req0_b);
            end else if (w == 1) begin
                m_valid <= 1'b1; m_id <= 1'b1; m_last <= 1'b1;
                m_data  <= op_result(req1_op, req1_a, req1_b);
            end else if (m_valid && rsp_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin : cmp
        int w;
        #2;
        if (m_known) begin
            w = winner();
            checks = checks + 1;
            if (req0_ready !== (w == 0) || req1_ready !== (w == 1)) begin
                errors = errors + 1;
                $display("FAIL model_ready t=%0t got r0=%b r1=%b want winner=%0d", $time,
                         req0_ready, req1_ready, w);
            end
            checks = checks + 1;
            if (rsp_valid !== m_valid || rsp_id !== m_id || rsp_data !== m_data) begin
                errors = errors + 1;
                $display("FAIL model_rsp t=%0t got v=%b id=%b d=%h want v=%b id=%b d=%h",
                         $time, rsp_valid, rsp_id, rsp_data, m_valid, m_id, m_data);
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
        end
    endtask

    // Advance to the next negedge (inputs are then driven by the caller).
    task automatic nxt();
        @(negedge clock);
    endtask

    // Let combinational outputs settle after driving, before literal checks.
    task automatic settle();
        #3;
    endtask

    logic [W-1:0] sweep_exp [4];

    initial begin
        reset = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_op = 2'd0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 2'd0; req1_a = '0; req1_b = '0;
        nxt(); settle();
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'h0000_0000);
        nxt();

        // 1: single request from req0
        reset = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'hF0F0_F0F0; req0_b = 32'hFF00_FF00;
        settle();
        chk("t1_ready0", {31'd0, req0_ready}, 32'd1);
        nxt(); req0_valid = 1'b0; settle();
        chk("t1_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t1_id", {31'd0, rsp_id}, 32'd0);
        chk("t1_data", rsp_data, 32'hF000_F000);
        nxt(); settle();
        chk("t1_drain", {31'd0, rsp_valid}, 32'd0);

        // 2: continuous contention after a fresh reset
        nxt(); reset = 1'b1;
        nxt(); reset = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'h0000_00FF; req0_b = 32'h0000_FF00;
        req1_valid = 1'b1; req1_op = 2'b10; req1_a = 32'hFFFF_FFFF; req1_b = 32'h1234_5678;
        settle();
        chk("t2_first_grant0", {30'd0, req1_ready, req0_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            nxt(); settle();
            chk("t2_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t2_id", {31'd0, rsp_id}, (k % 2 == 0) ? 32'd0 : 32'd1);
            chk("t2_data", rsp_data, (k % 2 == 0) ? 32'h0000_FFFF : 32'hEDCB_A987);
        end
        nxt(); req0_valid = 1'b0; req1_valid = 1'b0;

        // 3: backpressure
        nxt(); rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 2'b11; req1_a = 32'hFFFF_0000; req1_b = 32'h0F0F_0F0F;
        settle();
        chk("t3_ready1", {31'd0, req1_ready}, 32'd1);
        nxt(); req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'h1234_5678; req0_b = 32'h0F0F_0F0F;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("t3_hold_data", rsp_data, 32'hF0F0_0000);
            chk("t3_hold_id", {31'd0, rsp_id}, 32'd1);
            chk("t3_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            nxt();
        end
        rsp_ready = 1'b1; settle();
        chk("t3_refill_ready0", {31'd0, req0_ready}, 32'd1);
        nxt(); req0_valid = 1'b0; settle();
        chk("t3_new_id", {31'd0, rsp_id}, 32'd0);
        chk("t3_new_data", rsp_data, 32'h0204_0608);

        // 4: fairness pointer
        nxt();
        req1_valid = 1'b1; req1_op = 2'b01; req1_a = 32'h0000_0000; req1_b = 32'h0000_0005;
        settle();
        chk("t4_req1_alone", {31'd0, req1_ready}, 32'd1);
        nxt();
        req0_valid = 1'b1; req0_op = 2'b10; req0_a = 32'h0000_00FF; req0_b = 32'h0000_000F;
        settle();
        chk("t4_both_req0_first", {30'd0, req1_ready, req0_ready}, 32'd1);
        nxt(); req0_valid = 1'b0; settle();
        chk("t4_req1_after", {31'd0, req1_ready}, 32'd1);
        chk("t4_data_req0", rsp_data, 32'h0000_00F0);
        nxt(); req0_valid = 1'b1; settle();
        chk("t4_pointer1_req0_wins", {30'd0, req1_ready, req0_ready}, 32'd1);
        chk("t4_data_req1", rsp_data, 32'h0000_0005);
        nxt(); req0_valid = 1'b0; req1_valid = 1'b0;

        // 5: reset while holding a result
        nxt(); rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'h0000_00A0; req0_b = 32'h0000_000B;
        nxt(); reset = 1'b1; req0_op = 2'b00; req0_a = 32'h0000_00FF; req0_b = 32'h0000_000F;
        settle();
        chk("t5_held_data", rsp_data, 32'h0000_00AB);
        chk("t5_ready_in_reset", {31'd0, req0_ready}, 32'd0);
        nxt(); reset = 1'b0; settle();
        chk("t5_discarded", {31'd0, rsp_valid}, 32'd0);
        chk("t5_ready_after", {31'd0, req0_ready}, 32'd1);
        nxt(); req0_valid = 1'b0; rsp_ready = 1'b1; settle();
        chk("t5_result", rsp_data, 32'h0000_000F);
        chk("t5_valid", {31'd0, rsp_valid}, 32'd1);

        // 6: op sweep, one op per cycle
        sweep_exp[0] = 32'h8888_8888; sweep_exp[1] = 32'hEEEE_EEEE;
        sweep_exp[2] = 32'h6666_6666; sweep_exp[3] = 32'h2222_2222;
        nxt();
        req0_valid = 1'b1; req0_a = 32'hAAAA_AAAA; req0_b = 32'hCCCC_CCCC;
        for (int k = 0; k < 4; k++) begin
            req0_op = k[1:0];
            settle();
            chk("t6_ready", {31'd0, req0_ready}, 32'd1);
            nxt();
        end
        req0_valid = 1'b0; settle();
        chk("t6_last_op", rsp_data, sweep_exp[3]);
        for (int k = 0; k < 4; k++) begin
            chk("t6_model_pin", op_result(k[1:0], 32'hAAAA_AAAA, 32'hCCCC_CCCC), sweep_exp[k]);
        end

        nxt(); nxt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
